mux_arb: RTL and testbench

MUX_ARB -- requirements
Module: mux_arb

---
 rtl/mux_arb.sv | 185 ++++++++++++++++++
 tb/tb_mux_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb.sv
// N-way packet arbiter. Each requester has a one-entry buffer feeding a registered output.
// Round-robin grant in IDLE; a multi-beat packet holds the output until its last beat.

module mux_arb_lane #(
    parameter int W = 128
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         enq_ena,
    input  logic [W-1:0] enq_v,
    input  logic         enq_last,
    input  logic         move,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         last,
    output logic         rdy
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;
    logic         load;

    // Ready while moving out, so a lane can stream one beat per cycle.
    assign rdy  = !valid_q | move;
    assign load = enq_ena & rdy;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = enq_v;
            last_d  = enq_last;
        end else if (move) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign last  = last_q;
endmodule

module mux_arb #(
    parameter int N   = 4,
    parameter int W   = 128,
    parameter int IDW = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   req_enq__ENA,
    input  logic [N*W-1:0] req_enq_v,
    input  logic [N-1:0]   req_enq_last,
    output logic [N-1:0]   req_enq__RDY,
    output logic           out_enq__ENA,
    output logic [W-1:0]   out_enq_v,
    output logic           out_enq_last,
    output logic [IDW-1:0] out_enq_id,
    input  logic           out_enq__RDY
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       own_q, own_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic                 ovalid_q, ovalid_d;
    logic [W-1:0]         odata_q, odata_d;
    logic                 olast_q, olast_d;
    logic [IDW-1:0]       oid_q, oid_d;

    logic [N-1:0]         lane_valid;
    logic [N-1:0]         lane_last;
    logic [N-1:0][W-1:0]  lane_data;
    logic [N-1:0]         move;
    logic                 free;
    logic                 grant;
    logic [IDW-1:0]       sel;

    for (genvar i = 0; i < N; i++) begin : g_lane
        mux_arb_lane #(.W(W)) u_lane (
            .CLK      (CLK),
            .RST      (RST),
            .enq_ena  (req_enq__ENA[i]),
            .enq_v    (req_enq_v[i*W +: W]),
            .enq_last (req_enq_last[i]),
            .move     (move[i]),
            .valid    (lane_valid[i]),
            .data     (lane_data[i]),
            .last     (lane_last[i]),
            .rdy      (req_enq__RDY[i])
        );
    end

    assign free = !ovalid_q | out_enq__RDY;

    // Search ptr+1 .. ptr+N; the index wraps naturally since N is a power of two.
    always_comb begin
        logic [IDW-1:0] idx;
        grant = 1'b0;
        sel   = '0;
        idx   = '0;
        if (free) begin
            if (state_q == LOCKED) begin
                if (lane_valid[own_q]) begin
                    grant = 1'b1;
                    sel   = own_q;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    idx = ptr_q + IDW'(k);
                    if (!grant && lane_valid[idx]) begin
                        grant = 1'b1;
                        sel   = idx;
                    end
                end
            end
        end
        move = grant ? (N'(1) << sel) : '0;
    end

    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        ptr_d    = ptr_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        oid_d    = oid_q;
        if (grant) begin
            ovalid_d = 1'b1;
            odata_d  = lane_data[sel];
            olast_d  = lane_last[sel];
            oid_d    = sel;
            if (state_q == IDLE) begin
                ptr_d = sel;
                if (!lane_last[sel]) begin
                    state_d = LOCKED;
                    own_d   = sel;
                end
            end else if (lane_last[sel]) begin
                state_d = IDLE;
            end
        end else if (free) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            own_q    <= '0;
            ptr_q    <= IDW'(N - 1);
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            oid_q    <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            ptr_q    <= ptr_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            oid_q    <= oid_d;
        end
    end

    assign out_enq__ENA = ovalid_q;
    assign out_enq_v    = odata_q;
    assign out_enq_last = olast_q;
    assign out_enq_id   = oid_q;
endmodule

// File: tb/tb_mux_arb.sv
// Bench for mux_arb: cycle model plus per-requester order scoreboard under random traffic,
// with directed scenarios pinning single beat, round-robin, lock, backpressure, streaming, reset.

module tb_mux_arb;
    localparam int N = 4, W = 128, IDW = 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [N-1:0]   req_ena = '0;
    logic [N*W-1:0] req_v = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_rdy;
    logic           out_ena;
    logic [W-1:0]   out_v;
    logic           out_last;
    logic [IDW-1:0] out_id;
    logic           out_rdy = 1'b1;

    int checks = 0, fails = 0;

    mux_arb #(.N(N), .W(W), .IDW(IDW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_enq__ENA (req_ena),
        .req_enq_v    (req_v),
        .req_enq_last (req_last),
        .req_enq__RDY (req_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq_last (out_last),
        .out_enq_id   (out_id),
        .out_enq__RDY (out_rdy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [W-1:0] d; bit l; } beat_t;
    bit           m_val[N];
    logic [W-1:0] m_dat[N];
    bit           m_lst[N];
    bit           m_ov, m_ol;
    logic [W-1:0] m_od;
    int           m_oid, m_ptr, m_lock;
    beat_t        sb[N][$];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_val[i] = 0; m_dat[i] = '0; m_lst[i] = 0; sb[i].delete();
        end
        m_ov = 0; m_od = '0; m_ol = 0; m_oid = 0; m_ptr = N - 1; m_lock = -1;
    endtask

    task automatic check_cycle();
        bit free;
        int sel;
        logic [N-1:0] exp_rdy;
        beat_t b;
        chk("out_ena", out_ena, m_ov);
        if (m_ov) begin
            chk("out_v", out_v, m_od);
            chk("out_last", out_last, m_ol);
            chk("out_id", out_id, m_oid);
        end
        free = !m_ov || out_rdy;
        sel = -1;
        if (free) begin
            if (m_lock >= 0) begin
                if (m_val[m_lock]) sel = m_lock;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (m_val[(m_ptr + k) % N]) begin
                        sel = (m_ptr + k) % N;
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) exp_rdy[i] = !m_val[i] || (sel == i);
        chk("req_rdy", req_rdy, exp_rdy);
        if (out_ena && out_rdy && !RST) begin
            if (sb[out_id].size() == 0) begin
                chk("sb_unexpected_beat", out_id, N);
            end else begin
                b = sb[out_id].pop_front();
                chk("sb_order_v", out_v, b.d);
                chk("sb_order_last", out_last, b.l);
            end
        end
        if (RST) begin
            model_reset();
        end else begin
            if (sel >= 0) begin
                m_ov = 1; m_od = m_dat[sel]; m_ol = m_lst[sel]; m_oid = sel;
                if (m_lock < 0) begin
                    m_ptr = sel;
                    if (!m_lst[sel]) m_lock = sel;
                end else if (m_lst[sel]) begin
                    m_lock = -1;
                end
            end else if (free) begin
                m_ov = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ena[i] && exp_rdy[i]) begin
                    m_val[i] = 1; m_dat[i] = req_v[i*W +: W]; m_lst[i] = req_last[i];
                    b.d = req_v[i*W +: W]; b.l = req_last[i];
                    sb[i].push_back(b);
                end else if (sel == i) begin
                    m_val[i] = 0;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            #2;
            check_cycle();
        end
    end

    // Accepted output beats, for the directed scenarios.
    beat_t obs[$];
    int    obs_id[$];
    initial forever begin
        @(negedge CLK);
        #1;
        if (out_ena && out_rdy && !RST) begin
            obs.push_back('{out_v, out_last});
            obs_id.push_back(int'(out_id));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(); @(negedge CLK); endtask

    task automatic idle_in();
        req_ena = '0; req_last = '0; req_v = '0;
    endtask

    task automatic drive(input int i, input logic [W-1:0] v, input bit l);
        req_ena[i] = 1'b1; req_v[i*W +: W] = v; req_last[i] = l;
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b1; idle_in(); out_rdy = 1'b1;
        tick();
        RST = 1'b0;
        obs.delete(); obs_id.delete();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int c = 0;
        while (obs.size() < n && c < budget) begin tick(); c++; end
        chk("beat_count", obs.size(), n);
    endtask

    initial begin
        int n;
        logic [W-1:0] hv;
        tick(); tick();

        // Single beat from requester 2: visible two cycles after enqueue.
        do_reset();
        drive(2, 'hA5, 1);
        tick(); idle_in();
        chk("single_ena_t1", out_ena, 0);
        tick();
        chk("single_ena", out_ena, 1);
        chk("single_v", out_v, 'hA5);
        chk("single_id", out_id, 2);
        chk("single_last", out_last, 1);

        // Round-robin with all four requesters streaming single-beat packets.
        do_reset();
        n = 0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) drive(i, W'(c * 16 + i), 1);
            tick();
            if (out_ena) begin
                chk("rr_id", out_id, n % N);
                n++;
            end
        end
        idle_in();
        chk("rr_beats", n, 11);

        // Lock: requester 1 three-beat packet, requester 0 waits.
        do_reset();
        drive(1, 'h11, 0);
        tick();
        drive(1, 'h12, 0); drive(0, 'h01, 1);
        tick();
        idle_in(); drive(1, 'h13, 1);
        tick(); idle_in();
        wait_beats(4, 20);
        if (obs.size() == 4) begin
            chk("lock_id0", obs_id[0], 1); chk("lock_v0", obs[0].d, 'h11);
            chk("lock_id1", obs_id[1], 1); chk("lock_v1", obs[1].d, 'h12);
            chk("lock_id2", obs_id[2], 1); chk("lock_v2", obs[2].d, 'h13);
            chk("lock_id3", obs_id[3], 0); chk("lock_v3", obs[3].d, 'h01);
        end

        // Backpressure: five cycles stalled, then drain in round-robin order.
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++) drive(i, W'('h40 + i), 1);
        tick(); idle_in();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("bp_ena", out_ena, 1);
            chk("bp_id", out_id, 0);
            chk("bp_v", out_v, 'h40);
            chk("bp_rdy", req_rdy, 4'b0001);
        end
        out_rdy = 1'b1;
        wait_beats(4, 20);
        if (obs.size() == 4)
            for (int i = 0; i < N; i++) begin
                chk("bp_drain_id", obs_id[i], i);
                chk("bp_drain_v", obs[i].d, W'('h40 + i));
            end

        // Streaming: requester 3 alone, eight back-to-back beats.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            idle_in();
            if (k < 8) drive(3, W'('h300 + k), k == 7);
            #1;
            if (k < 8) chk("st_rdy3", req_rdy[3], 1);
            tick();
            chk("st_ena", out_ena, k >= 1 && k <= 8);
        end
        idle_in();
        wait_beats(8, 10);
        if (obs.size() == 8)
            for (int k = 0; k < 8; k++) chk("st_v", obs[k].d, W'('h300 + k));

        // Reset mid-packet from requester 1.
        do_reset();
        drive(1, 'h21, 0); tick();
        drive(1, 'h22, 0); tick();
        idle_in(); drive(1, 'h23, 0);
        tick();
        RST = 1'b1; idle_in();
        tick();
        chk("rst_ena", out_ena, 0);
        chk("rst_rdy", req_rdy, 4'hF);
        RST = 1'b0;
        obs.delete(); obs_id.delete();
        drive(2, 'h27, 1); drive(0, 'h07, 1);
        tick(); idle_in();
        wait_beats(2, 10);
        if (obs.size() == 2) begin
            chk("rst_first_id", obs_id[0], 0); chk("rst_first_v", obs[0].d, 'h07);
            chk("rst_second_id", obs_id[1], 2); chk("rst_second_v", obs[1].d, 'h27);
        end

        // Random traffic; the model and scoreboard check every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_ena = N'($urandom);
            for (int i = 0; i < N; i++) begin
                hv = {$urandom, $urandom, $urandom, $urandom};
                req_v[i*W +: W] = hv;
                req_last[i] = ($urandom % 3) != 0;
            end
            out_rdy = ($urandom % 4) != 0;
            RST = ($urandom % 500) == 0;
            tick();
        end
        RST = 1'b0; idle_in(); out_rdy = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
